// File: rtl/display_pkg.sv
// Shared constants for the multiplexed seven-segment display.
// Segment words are active-low {g,f,e,d,c,b,a}.
package display_pkg;

    localparam int       NUM_DIGITS = 4;
    localparam logic [7:0] AN_ALL_OFF = 8'hFF;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph.
// Ports: i_nib (4-bit value), o_seg ({g,f,e,d,c,b,a}, active-low).
module hex_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_GLYPH[i_nib];

endmodule

// File: rtl/bcd_seg_display.sv
// Four-digit time-multiplexed driver: op_code hex on digit 3, BCD on 2..0.
// Ports: clk, reset (sync, high), bcd, op_code, c_out, hold -> an, seg, dp.
module bcd_seg_display
    import display_pkg::*;
#(
    parameter int   REFRESH_DIV = 100000,
    parameter logic BLANK_ZEROS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] bcd,
    input  logic [3:0]  op_code,
    input  logic        c_out,
    input  logic        hold,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [1:0] IDX_LAST = 2'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [11:0]      r_bcd;
    logic [3:0]       r_op;
    logic             r_cout;
    logic [7:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    logic             w_wrap;
    logic             w_frame;
    logic [3:0]       w_nib;
    logic [6:0]       w_glyph;
    logic             w_hund_zero;
    logic             w_tens_zero;
    logic             w_blank;
    logic             w_bad;
    logic [6:0]       w_seg_nx;
    logic [7:0]       w_an_nx;
    logic             w_dp_nx;

    assign w_wrap  = (r_cnt == CNT_MAX);
    assign w_frame = w_wrap && (r_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Snapshot only moves at the frame edge so a scan never mixes values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcd  <= '0;
            r_op   <= '0;
            r_cout <= 1'b0;
        end else if (w_frame && !hold) begin
            r_bcd  <= bcd;
            r_op   <= op_code;
            r_cout <= c_out;
        end
    end

    always_comb begin
        w_nib = r_bcd[3:0];
        case (r_idx)
            2'd0:    w_nib = r_bcd[3:0];
            2'd1:    w_nib = r_bcd[7:4];
            2'd2:    w_nib = r_bcd[11:8];
            default: w_nib = r_op;
        endcase
    end

    hex_to_seg7 u_hex (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

    // An invalid nibble is non-zero, so it can never trigger blanking
    // of itself or of any digit below it.
    assign w_hund_zero = (r_bcd[11:8] == 4'd0);
    assign w_tens_zero = w_hund_zero && (r_bcd[7:4] == 4'd0);
    assign w_bad       = (r_idx != IDX_LAST) && (w_nib > 4'd9);

    always_comb begin
        w_blank = 1'b0;
        if (BLANK_ZEROS) begin
            case (r_idx)
                2'd1:    w_blank = w_tens_zero;
                2'd2:    w_blank = w_hund_zero;
                default: w_blank = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_seg_nx = w_glyph;
        if (w_bad) begin
            w_seg_nx = SEG_E;
        end else if (w_blank) begin
            w_seg_nx = SEG_BLANK;
        end
    end

    assign w_an_nx = ~(8'd1 << r_idx);
    assign w_dp_nx = ~((r_idx == 2'd0) && r_cout);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= AN_ALL_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_nx;
            r_seg <= w_seg_nx;
            r_dp  <= w_dp_nx;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
